// File: rtl/alu_pkg.sv
// Shared opcode encodings, FSM state type and sizing constants for the
// 16-bit accumulator ALU.
package alu_pkg;

    localparam int unsigned OPCODE_W = 4;
    localparam int unsigned SHCNT_W  = 4;

    localparam logic [OPCODE_W-1:0] OP_NOP  = 4'd0;
    localparam logic [OPCODE_W-1:0] OP_LOAD = 4'd1;
    localparam logic [OPCODE_W-1:0] OP_NAND = 4'd2;
    localparam logic [OPCODE_W-1:0] OP_AND  = 4'd3;
    localparam logic [OPCODE_W-1:0] OP_OR   = 4'd4;
    localparam logic [OPCODE_W-1:0] OP_XOR  = 4'd5;
    localparam logic [OPCODE_W-1:0] OP_NOT  = 4'd6;
    localparam logic [OPCODE_W-1:0] OP_ADD  = 4'd7;
    localparam logic [OPCODE_W-1:0] OP_SUB  = 4'd8;
    localparam logic [OPCODE_W-1:0] OP_SHL  = 4'd9;
    localparam logic [OPCODE_W-1:0] OP_SHR  = 4'd10;
    localparam logic [OPCODE_W-1:0] OP_CLR  = 4'd11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

endpackage

// File: rtl/alu_core16.sv
// Single-cycle result and flag logic. Shift opcodes pass acc through with
// cleared flags; the multi-cycle shift itself is sequenced by the top.
module alu_core16
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic [OPCODE_W-1:0] opcode,
    input  logic [WIDTH-1:0]    acc,
    input  logic [WIDTH-1:0]    operand,
    output logic [WIDTH-1:0]    result,
    output logic                carry,
    output logic                zero,
    output logic                ovf,
    output logic                err
);

    logic [WIDTH:0]   sumWide;
    logic [WIDTH-1:0] diff;

    assign sumWide = {1'b0, acc} + {1'b0, operand};
    assign diff    = acc - operand;

    always_comb begin
        result = acc;
        carry  = 1'b0;
        ovf    = 1'b0;
        err    = 1'b0;
        case (opcode)
            OP_NOP:  result = acc;
            OP_LOAD: result = operand;
            OP_NAND: result = ~(acc & operand);
            OP_AND:  result = acc & operand;
            OP_OR:   result = acc | operand;
            OP_XOR:  result = acc ^ operand;
            OP_NOT:  result = ~acc;
            OP_ADD: begin
                result = sumWide[WIDTH-1:0];
                carry  = sumWide[WIDTH];
                ovf    = (acc[WIDTH-1] == operand[WIDTH-1]) && (sumWide[WIDTH-1] != acc[WIDTH-1]);
            end
            OP_SUB: begin
                // carry reports an unsigned borrow
                result = diff;
                carry  = acc < operand;
                ovf    = (acc[WIDTH-1] != operand[WIDTH-1]) && (diff[WIDTH-1] != acc[WIDTH-1]);
            end
            OP_SHL, OP_SHR: result = acc;
            OP_CLR:  result = '0;
            default: err = 1'b1;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/alu_acc16.sv
// Accumulator ALU with valid/ready handshakes: one-cycle ops respond on the
// next cycle, shifts step one bit per cycle before responding.
module alu_acc16
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic [WIDTH-1:0]    in,
    output logic [WIDTH-1:0]    out,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                carry,
    output logic                zero,
    output logic                ovf,
    output logic                err
);

    state_t               state, stateNext;
    logic [WIDTH-1:0]     acc, accNext, shifted;
    logic [SHCNT_W-1:0]   shiftCnt, shiftCntNext;
    logic                 shiftLeft, shiftLeftNext;
    logic                 carryNext, zeroNext, ovfNext, errNext;

    logic [WIDTH-1:0]     coreResult;
    logic                 coreCarry, coreZero, coreOvf, coreErr;

    alu_core16 #(.WIDTH(WIDTH)) uCore (
        .opcode  (opcode),
        .acc     (acc),
        .operand (in),
        .result  (coreResult),
        .carry   (coreCarry),
        .zero    (coreZero),
        .ovf     (coreOvf),
        .err     (coreErr)
    );

    assign shifted = shiftLeft ? {acc[WIDTH-2:0], 1'b0} : {1'b0, acc[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            acc       <= '0;
            shiftCnt  <= '0;
            shiftLeft <= 1'b0;
            carry     <= 1'b0;
            zero      <= 1'b1;
            ovf       <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= stateNext;
            acc       <= accNext;
            shiftCnt  <= shiftCntNext;
            shiftLeft <= shiftLeftNext;
            carry     <= carryNext;
            zero      <= zeroNext;
            ovf       <= ovfNext;
            err       <= errNext;
        end
    end

    always_comb begin
        stateNext     = state;
        accNext       = acc;
        shiftCntNext  = shiftCnt;
        shiftLeftNext = shiftLeft;
        carryNext     = carry;
        zeroNext      = zero;
        ovfNext       = ovf;
        errNext       = err;
        case (state)
            ST_IDLE: begin
                if (in_valid) begin
                    accNext   = coreResult;
                    carryNext = coreCarry;
                    zeroNext  = coreZero;
                    ovfNext   = coreOvf;
                    errNext   = coreErr;
                    // A zero-length shift completes like any single-cycle op
                    if ((opcode == OP_SHL || opcode == OP_SHR) && in[SHCNT_W-1:0] != '0) begin
                        stateNext     = ST_SHIFT;
                        shiftCntNext  = in[SHCNT_W-1:0];
                        shiftLeftNext = (opcode == OP_SHL);
                    end else begin
                        stateNext = ST_RESP;
                    end
                end
            end
            ST_SHIFT: begin
                accNext      = shifted;
                carryNext    = shiftLeft ? acc[WIDTH-1] : acc[0];
                zeroNext     = (shifted == '0);
                shiftCntNext = shiftCnt - SHCNT_W'(1);
                if (shiftCnt == SHCNT_W'(1)) begin
                    stateNext = ST_RESP;
                end
            end
            ST_RESP: begin
                if (out_ready) begin
                    stateNext = ST_IDLE;
                end
            end
            default: stateNext = ST_IDLE;
        endcase
    end

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_RESP);
    assign out       = acc;

endmodule

// File: tb/tb_alu_acc16.sv
// Directed self-checking bench for alu_acc16.
module tb_alu_acc16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  opcode = 4'd0;
    logic [15:0] in = 16'h0000;
    logic [15:0] out;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        carry, zero, ovf, err;

    int nChecks = 0;
    int nFails  = 0;

    alu_acc16 #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opcode    (opcode),
        .in        (in),
        .out       (out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .carry     (carry),
        .zero      (zero),
        .ovf       (ovf),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Present one command for a single cycle; returns #1 after the accepting edge.
    task automatic send(input logic [3:0] op, input logic [15:0] data);
        int waitCyc;
        waitCyc = 0;
        while (!in_ready && waitCyc < 50) begin
            @(posedge clk); #1;
            waitCyc++;
        end
        opcode   = op;
        in       = data;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        nChecks++; if (out !== 16'h0000)  begin nFails++; $display("FAIL reset_out got=%h exp=0000", out); end
        nChecks++; if (zero !== 1'b1)     begin nFails++; $display("FAIL reset_zero got=%b exp=1", zero); end
        nChecks++; if ({carry, ovf, err} !== 3'b000) begin nFails++; $display("FAIL reset_flags got=%b exp=000", {carry, ovf, err}); end
        nChecks++; if (out_valid !== 1'b0) begin nFails++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        nChecks++; if (in_ready !== 1'b1)  begin nFails++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_logic();
        send(4'd1, 16'h00FF);
        nChecks++; if (out_valid !== 1'b1 || out !== 16'h00FF) begin nFails++; $display("FAIL load_ff got=%h/%b exp=00ff/1", out, out_valid); end
        consume();
        send(4'd2, 16'hFF55);
        nChecks++; if (out_valid !== 1'b1) begin nFails++; $display("FAIL nand_latency out_valid got=%b exp=1", out_valid); end
        nChecks++; if (out !== 16'hFFAA)   begin nFails++; $display("FAIL nand_out got=%h exp=ffaa", out); end
        nChecks++; if ({zero, carry, ovf, err} !== 4'b0000) begin nFails++; $display("FAIL nand_flags got=%b exp=0000", {zero, carry, ovf, err}); end
        consume();
        send(4'd5, 16'hFFAA);
        nChecks++; if (out !== 16'h0000 || zero !== 1'b1) begin nFails++; $display("FAIL xor_zero got=%h/%b exp=0000/1", out, zero); end
        consume();
        send(4'd6, 16'h0000);
        nChecks++; if (out !== 16'hFFFF || zero !== 1'b0) begin nFails++; $display("FAIL not_out got=%h/%b exp=ffff/0", out, zero); end
        consume();
    endtask

    task automatic test_add_sub();
        send(4'd1, 16'h7FFF); consume();
        send(4'd7, 16'h0001);
        nChecks++; if (out !== 16'h8000) begin nFails++; $display("FAIL add1_out got=%h exp=8000", out); end
        nChecks++; if ({ovf, carry, zero} !== 3'b100) begin nFails++; $display("FAIL add1_flags ovf,carry,zero got=%b exp=100", {ovf, carry, zero}); end
        consume();
        send(4'd7, 16'h8000);
        nChecks++; if (out !== 16'h0000) begin nFails++; $display("FAIL add2_out got=%h exp=0000", out); end
        nChecks++; if ({ovf, carry, zero} !== 3'b111) begin nFails++; $display("FAIL add2_flags ovf,carry,zero got=%b exp=111", {ovf, carry, zero}); end
        consume();
        send(4'd1, 16'h0001); consume();
        send(4'd8, 16'h0002);
        nChecks++; if (out !== 16'hFFFF) begin nFails++; $display("FAIL sub_out got=%h exp=ffff", out); end
        nChecks++; if ({ovf, carry, zero} !== 3'b010) begin nFails++; $display("FAIL sub_flags ovf,carry,zero got=%b exp=010", {ovf, carry, zero}); end
        consume();
        send(4'd11, 16'h1234);
        nChecks++; if (out !== 16'h0000 || {zero, carry, ovf} !== 3'b100) begin nFails++; $display("FAIL clr got=%h/%b exp=0000/100", out, {zero, carry, ovf}); end
        consume();
    endtask

    task automatic test_shift();
        int cyc;
        send(4'd1, 16'h8001); consume();
        send(4'd9, 16'h0003);
        cyc = 1;
        while (!out_valid && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        nChecks++; if (cyc !== 4)        begin nFails++; $display("FAIL shl_latency got=%0d exp=4", cyc); end
        nChecks++; if (out !== 16'h0008) begin nFails++; $display("FAIL shl_out got=%h exp=0008", out); end
        nChecks++; if ({carry, ovf} !== 2'b00) begin nFails++; $display("FAIL shl_flags carry,ovf got=%b exp=00", {carry, ovf}); end
        consume();
        send(4'd9, 16'h000D);
        cyc = 1;
        while (!out_valid && cyc < 30) begin
            @(posedge clk); #1;
            cyc++;
        end
        nChecks++; if (cyc !== 14 || out !== 16'h0000 || carry !== 1'b1 || zero !== 1'b1) begin nFails++; $display("FAIL shl13 got=%0d/%h/%b/%b exp=14/0000/1/1", cyc, out, carry, zero); end
        consume();
        send(4'd1, 16'h0008); consume();
        send(4'd10, 16'h0000);
        nChecks++; if (out_valid !== 1'b1 || out !== 16'h0008 || carry !== 1'b0) begin nFails++; $display("FAIL shr0 got=%b/%h/%b exp=1/0008/0", out_valid, out, carry); end
        consume();
        send(4'd10, 16'h0002);
        @(posedge clk); #1; @(posedge clk); #1;
        nChecks++; if (out_valid !== 1'b1 || out !== 16'h0002 || carry !== 1'b0) begin nFails++; $display("FAIL shr2 got=%b/%h/%b exp=1/0002/0", out_valid, out, carry); end
        consume();
    endtask

    task automatic test_hold_and_illegal();
        send(4'd1, 16'h1234);
        for (int i = 0; i < 5; i++) begin
            in_valid = (i % 2 == 0);
            opcode   = 4'd1;
            in       = 16'hDEAD;
            @(posedge clk); #1;
            nChecks++; if (out !== 16'h1234 || out_valid !== 1'b1 || in_ready !== 1'b0) begin nFails++; $display("FAIL hold_cycle%0d got=%h/%b/%b exp=1234/1/0", i, out, out_valid, in_ready); end
        end
        in_valid = 1'b0;
        consume();
        nChecks++; if (out !== 16'h1234 || in_ready !== 1'b1 || out_valid !== 1'b0) begin nFails++; $display("FAIL hold_release got=%h/%b/%b exp=1234/1/0", out, in_ready, out_valid); end
        send(4'd0, 16'hFFFF);
        nChecks++; if (out !== 16'h1234 || out_valid !== 1'b1 || err !== 1'b0) begin nFails++; $display("FAIL nop got=%h/%b/%b exp=1234/1/0", out, out_valid, err); end
        consume();
        send(4'd13, 16'h5555);
        nChecks++; if (out !== 16'h1234 || out_valid !== 1'b1) begin nFails++; $display("FAIL illegal_out got=%h/%b exp=1234/1", out, out_valid); end
        nChecks++; if ({err, carry, ovf, zero} !== 4'b1000) begin nFails++; $display("FAIL illegal_flags err,carry,ovf,zero got=%b exp=1000", {err, carry, ovf, zero}); end
        consume();
    endtask

    task automatic test_reset_mid_shift();
        send(4'd1, 16'hFFFF); consume();
        send(4'd9, 16'h0008);
        @(posedge clk); #1;
        nChecks++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin nFails++; $display("FAIL midshift_busy got=%b/%b exp=0/0", out_valid, in_ready); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        nChecks++; if (out !== 16'h0000 || zero !== 1'b1) begin nFails++; $display("FAIL midshift_rst_acc got=%h/%b exp=0000/1", out, zero); end
        nChecks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin nFails++; $display("FAIL midshift_rst_hs got=%b/%b exp=0/1", out_valid, in_ready); end
        @(posedge clk); #1; @(posedge clk); #1;
        nChecks++; if (out_valid !== 1'b0 || out !== 16'h0000) begin nFails++; $display("FAIL midshift_no_resp got=%b/%h exp=0/0000", out_valid, out); end
    endtask

    initial begin
        test_reset();
        test_logic();
        test_add_sub();
        test_shift();
        test_hold_and_illegal();
        test_reset_mid_shift();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
